// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder: funct3 codes, FSM states,
// error causes and the debug view of the FSM.
package dmem_pkg;

   localparam int XLEN = 32;

   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;
   localparam logic [2:0] F3_SB  = 3'b000;
   localparam logic [2:0] F3_SH  = 3'b001;
   localparam logic [2:0] F3_SW  = 3'b010;

   typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

   typedef enum logic [1:0] {ERR_NONE, ERR_FUNCT3, ERR_RANGE, ERR_MISALIGN} err_cause_t;

   typedef struct packed {
      state_t     state;
      err_cause_t cause;
      logic       misalign;
   } dbg_t;

   function automatic logic f3_legal(input logic we, input logic [2:0] f3);
      if (we) return (f3 == F3_SB) || (f3 == F3_SH) || (f3 == F3_SW);
      return (f3 == F3_LB) || (f3 == F3_LH) || (f3 == F3_LW) ||
             (f3 == F3_LBU) || (f3 == F3_LHU);
   endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// Request/response bus between the core's load/store unit (master) and the
// data-memory responder (slave).
interface dmem_responder_if #(
   parameter int WIDTH_DATA = 32,
   parameter int WIDTH_ADDR = 32
);
   // Both channels use valid/ready: a transfer happens on a rising edge where
   // valid and ready are both 1; the sender holds its payload stable until then.
   logic                  req_valid;
   logic                  req_ready;
   logic                  req_we;
   logic [2:0]            req_funct3;
   logic [WIDTH_ADDR-1:0] req_addr;
   logic [WIDTH_DATA-1:0] req_wdata;
   logic                  rsp_valid;
   logic                  rsp_ready;
   logic [WIDTH_DATA-1:0] rsp_rdata;
   logic                  rsp_err;

   modport master (
      output req_valid, req_we, req_funct3, req_addr, req_wdata, rsp_ready,
      input  req_ready, rsp_valid, rsp_rdata, rsp_err
   );

   modport slave (
      input  req_valid, req_we, req_funct3, req_addr, req_wdata, rsp_ready,
      output req_ready, rsp_valid, rsp_rdata, rsp_err
   );
endinterface

// File: rtl/dmem_lane_align.sv
// Byte-lane steering for RV32I loads/stores: write mask, replicated write word,
// sign/zero-extended load data and the misalignment flag.
module dmem_lane_align
   import dmem_pkg::*;
(
   input  logic [2:0]      funct3_i,
   input  logic [1:0]      lane_i,
   input  logic [XLEN-1:0] wdata_i,
   input  logic [XLEN-1:0] rword_i,
   output logic [3:0]      wmask_o,
   output logic [XLEN-1:0] wword_o,
   output logic [XLEN-1:0] rdata_o,
   output logic            misalign_o
);
   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   always_comb begin
      wmask_o    = 4'b0000;
      wword_o    = '0;
      rdata_o    = '0;
      misalign_o = 1'b0;
      byte_sel   = rword_i[{lane_i, 3'b000} +: 8];
      half_sel   = lane_i[1] ? rword_i[31:16] : rword_i[15:0];
      // Data is replicated across lanes so the mask alone picks the target bytes;
      // ignoring low address bits here is what silently aligns misaligned accesses.
      case (funct3_i[1:0])
         2'b00: begin
            wmask_o = 4'b0001 << lane_i;
            wword_o = {4{wdata_i[7:0]}};
            rdata_o = funct3_i[2] ? {24'b0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
         end
         2'b01: begin
            misalign_o = lane_i[0];
            wmask_o    = lane_i[1] ? 4'b1100 : 4'b0011;
            wword_o    = {2{wdata_i[15:0]}};
            rdata_o    = funct3_i[2] ? {16'b0, half_sel} : {{16{half_sel[15]}}, half_sel};
         end
         2'b10: begin
            misalign_o = |lane_i;
            wmask_o    = 4'b1111;
            wword_o    = wdata_i;
            rdata_o    = rword_i;
         end
         default: ;
      endcase
   end
endmodule

// File: rtl/dmem_responder.sv
// RV32 data-memory responder: one request at a time, fixed LATENCY, separate
// response handshake. Define DMEM_MISALIGN_ERR_EN to flag misaligned accesses.
module dmem_responder
   import dmem_pkg::*;
#(
   parameter int WIDTH_DATA = 32,
   parameter int WIDTH_ADDR = 32,
   parameter int DEPTH      = 1024,
   parameter int LATENCY    = 2
) (
   input  logic                clk,
   input  logic                rst,
   dmem_responder_if.slave     bus,
   output dbg_t                dbg_o
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
   localparam logic [WIDTH_ADDR-1:0] ADDR_LIMIT = WIDTH_ADDR'(DEPTH * 4);

   logic [XLEN-1:0] mem [DEPTH];

   state_t                state_q, state_d;
   logic [CW-1:0]         cnt_q, cnt_d;
   logic                  we_q;
   logic [2:0]            f3_q;
   logic [WIDTH_ADDR-1:0] addr_q;
   logic [XLEN-1:0]       wdata_q;
   logic [XLEN-1:0]       rdata_q, rdata_d;
   logic                  err_q, err_d;

   logic            accept, commit, misalign;
   logic [AW-1:0]   idx;
   logic [XLEN-1:0] rword, wword, rdata_ext;
   logic [3:0]      wmask;
   err_cause_t      cause;

   assign bus.req_ready = (state_q == IDLE);
   assign bus.rsp_valid = (state_q == RESP);
   assign bus.rsp_rdata = rdata_q;
   assign bus.rsp_err   = err_q;
   assign accept        = bus.req_valid && (state_q == IDLE);
   assign commit        = (state_q == BUSY) && (cnt_q == '0);
   assign idx           = addr_q[AW+1:2];
   assign rword         = mem[idx];

   dmem_lane_align u_align (
      .funct3_i   (f3_q),
      .lane_i     (addr_q[1:0]),
      .wdata_i    (wdata_q),
      .rword_i    (rword),
      .wmask_o    (wmask),
      .wword_o    (wword),
      .rdata_o    (rdata_ext),
      .misalign_o (misalign)
   );

   always_comb begin
      cause = ERR_NONE;
      if (!f3_legal(we_q, f3_q))     cause = ERR_FUNCT3;
      else if (addr_q >= ADDR_LIMIT) cause = ERR_RANGE;
`ifdef DMEM_MISALIGN_ERR_EN
      else if (misalign)             cause = ERR_MISALIGN;
`endif
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      rdata_d = rdata_q;
      err_d   = err_q;
      case (state_q)
         IDLE: if (bus.req_valid) begin
            state_d = BUSY;
            cnt_d   = CW'(LATENCY - 1);
         end
         BUSY: if (cnt_q == '0) begin
            state_d = RESP;
            err_d   = (cause != ERR_NONE);
            rdata_d = (we_q || cause != ERR_NONE) ? '0 : rdata_ext;
         end else begin
            cnt_d = cnt_q - 1'b1;
         end
         RESP: if (bus.rsp_ready) begin
            state_d = IDLE;
            rdata_d = '0;
            err_d   = 1'b0;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         rdata_q <= '0;
         err_q   <= 1'b0;
         we_q    <= 1'b0;
         f3_q    <= 3'b000;
         addr_q  <= '0;
         wdata_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
         if (accept) begin
            we_q    <= bus.req_we;
            f3_q    <= bus.req_funct3;
            addr_q  <= bus.req_addr;
            wdata_q <= bus.req_wdata[XLEN-1:0];
         end
      end
   end

   // Array is not reset; the !rst gate drops a store whose commit edge lands in reset.
   always_ff @(posedge clk) begin
      if (!rst && commit && we_q && cause == ERR_NONE) begin
         for (int i = 0; i < 4; i++) begin
            if (wmask[i]) mem[idx][8*i +: 8] <= wword[8*i +: 8];
         end
      end
   end

   assign dbg_o = '{state: state_q, cause: cause, misalign: misalign};

endmodule

// File: tb/tb_dmem_responder.sv
// Directed self-checking bench for dmem_responder (LATENCY=2, DEPTH=1024);
// honours DMEM_MISALIGN_ERR_EN when the build defines it.
module tb_dmem_responder;
   import dmem_pkg::*;

   logic clk = 1'b0;
   logic rst;
   dbg_t dbg;
   int   errors = 0;
   int   checks = 0;

   always #5 clk = ~clk;

   dmem_responder_if #(.WIDTH_DATA(32), .WIDTH_ADDR(32)) bus ();

   dmem_responder #(.WIDTH_DATA(32), .WIDTH_ADDR(32), .DEPTH(1024), .LATENCY(2)) dut (
      .clk   (clk),
      .rst   (rst),
      .bus   (bus),
      .dbg_o (dbg)
   );

   // Issues one request from a falling edge and waits for the response.
   // lat = falling edges after the accept edge until rsp_valid is seen.
   task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wdata, output logic [31:0] rdata,
                         output logic err, output int lat);
      int k;
      bus.req_we     = we;
      bus.req_funct3 = f3;
      bus.req_addr   = addr;
      bus.req_wdata  = wdata;
      bus.req_valid  = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.req_valid = 1'b0;
      k = 0;
      while (!bus.rsp_valid && k < 20) begin
         @(negedge clk);
         k++;
      end
      if (!bus.rsp_valid) begin
         checks++;
         errors++;
         $display("FAIL rsp_timeout: addr=%h rsp_valid=0 after %0d cycles, required 1", addr, k);
         rdata = '0;
         err   = 1'b0;
         lat   = -1;
      end else begin
         rdata = bus.rsp_rdata;
         err   = bus.rsp_err;
         lat   = k;
         if (bus.rsp_ready) begin
            @(posedge clk);
            @(negedge clk);
         end
      end
   endtask

   task automatic test_reset();
      repeat (2) @(negedge clk);
      checks++; if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready: got %b required 1", bus.req_ready); end
      checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid: got %b required 0", bus.rsp_valid); end
      checks++; if (bus.rsp_rdata !== 32'h0) begin errors++; $display("FAIL reset_rsp_rdata: got %h required 0", bus.rsp_rdata); end
      checks++; if (bus.rsp_err !== 1'b0) begin errors++; $display("FAIL reset_rsp_err: got %b required 0", bus.rsp_err); end
      checks++; if (dbg.state !== IDLE) begin errors++; $display("FAIL reset_state: got %0d required IDLE", dbg.state); end
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_word();
      logic [31:0] rd; logic er; int lat;
      do_req(1'b1, F3_SW, 32'h10, 32'hDEADBEEF, rd, er, lat);
      checks++; if (lat !== 2) begin errors++; $display("FAIL sw_latency: got %0d required 2", lat); end
      checks++; if (er !== 1'b0) begin errors++; $display("FAIL sw_err: got %b required 0", er); end
      checks++; if (rd !== 32'h0) begin errors++; $display("FAIL sw_rdata: got %h required 0", rd); end
      do_req(1'b0, F3_LW, 32'h10, 32'h0, rd, er, lat);
      checks++; if (rd !== 32'hDEADBEEF || er !== 1'b0) begin errors++; $display("FAIL lw_0x10: got %h/%b required deadbeef/0", rd, er); end
      checks++; if (lat !== 2) begin errors++; $display("FAIL lw_latency: got %0d required 2", lat); end
   endtask

   task automatic test_byte_half();
      logic [2:0]  f3_t  [7] = '{F3_LB, F3_LBU, F3_LW, F3_LH, F3_LHU, F3_LB, F3_LHU};
      logic [31:0] adr_t [7] = '{32'h13, 32'h13, 32'h10, 32'h12, 32'h12, 32'h11, 32'h10};
      logic [31:0] exp_t [7] = '{32'hFFFFFFA5, 32'h000000A5, 32'hA5ADBEEF, 32'hFFFFA5AD,
                                 32'h0000A5AD, 32'hFFFFFFBE, 32'h0000BEEF};
      logic [31:0] rd; logic er; int lat;
      do_req(1'b1, F3_SB, 32'h13, 32'h000000A5, rd, er, lat);
      checks++; if (er !== 1'b0) begin errors++; $display("FAIL sb_err: got %b required 0", er); end
      for (int i = 0; i < 7; i++) begin
         do_req(1'b0, f3_t[i], adr_t[i], 32'h0, rd, er, lat);
         checks++;
         if (rd !== exp_t[i] || er !== 1'b0) begin
            errors++;
            $display("FAIL load_%0d f3=%b addr=%h: got %h/%b required %h/0", i, f3_t[i], adr_t[i], rd, er, exp_t[i]);
         end
      end
      do_req(1'b1, F3_SH, 32'h22, 32'hFFFF1234, rd, er, lat);
      do_req(1'b1, F3_SB, 32'h20, 32'h00000077, rd, er, lat);
      do_req(1'b1, F3_SB, 32'h21, 32'h00000066, rd, er, lat);
      do_req(1'b0, F3_LW, 32'h20, 32'h0, rd, er, lat);
      checks++; if (rd !== 32'h12346677) begin errors++; $display("FAIL sh_sb_merge: got %h required 12346677", rd); end
   endtask

   task automatic test_backpressure();
      logic [31:0] rd; logic er; int lat;
      bus.rsp_ready = 1'b0;
      do_req(1'b0, F3_LW, 32'h10, 32'h0, rd, er, lat);
      checks++; if (rd !== 32'hA5ADBEEF) begin errors++; $display("FAIL bp_first: got %h required a5adbeef", rd); end
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         checks++;
         if (bus.rsp_valid !== 1'b1 || bus.rsp_rdata !== 32'hA5ADBEEF || bus.req_ready !== 1'b0) begin
            errors++;
            $display("FAIL bp_hold_%0d: valid=%b rdata=%h req_ready=%b required 1/a5adbeef/0",
                     i, bus.rsp_valid, bus.rsp_rdata, bus.req_ready);
         end
      end
      bus.rsp_ready = 1'b1;
      @(negedge clk);
      checks++;
      if (bus.rsp_valid !== 1'b0 || bus.req_ready !== 1'b1 || bus.rsp_rdata !== 32'h0) begin
         errors++;
         $display("FAIL bp_release: valid=%b req_ready=%b rdata=%h required 0/1/0",
                  bus.rsp_valid, bus.req_ready, bus.rsp_rdata);
      end
   endtask

   task automatic test_errors();
      logic [31:0] rd; logic er; int lat;
      do_req(1'b1, F3_SW, 32'h0, 32'h11223344, rd, er, lat);
      do_req(1'b1, F3_SW, 32'h1000, 32'hFFFFFFFF, rd, er, lat);
      checks++; if (er !== 1'b1 || rd !== 32'h0) begin errors++; $display("FAIL sw_range: got %h/%b required 0/1", rd, er); end
      checks++; if (lat !== 2) begin errors++; $display("FAIL err_latency: got %0d required 2", lat); end
      do_req(1'b1, 3'b011, 32'h0, 32'hFFFFFFFF, rd, er, lat);
      checks++; if (er !== 1'b1) begin errors++; $display("FAIL st_bad_f3: got err %b required 1", er); end
      do_req(1'b0, F3_LW, 32'h0, 32'h0, rd, er, lat);
      checks++; if (rd !== 32'h11223344 || er !== 1'b0) begin errors++; $display("FAIL lw_0_unchanged: got %h/%b required 11223344/0", rd, er); end
      do_req(1'b0, 3'b011, 32'h0, 32'h0, rd, er, lat);
      checks++; if (er !== 1'b1 || rd !== 32'h0) begin errors++; $display("FAIL ld_bad_f3: got %h/%b required 0/1", rd, er); end
      do_req(1'b0, F3_LBU, 32'h1000, 32'h0, rd, er, lat);
      checks++; if (er !== 1'b1 || rd !== 32'h0) begin errors++; $display("FAIL lbu_range: got %h/%b required 0/1", rd, er); end
      do_req(1'b1, F3_SW, 32'hFFC, 32'h0BADF00D, rd, er, lat);
      do_req(1'b0, F3_LW, 32'hFFC, 32'h0, rd, er, lat);
      checks++; if (rd !== 32'h0BADF00D || er !== 1'b0) begin errors++; $display("FAIL lw_last_word: got %h/%b required 0badf00d/0", rd, er); end
      do_req(1'b1, F3_SW, 32'h40, 32'h0, rd, er, lat);
      do_req(1'b1, F3_SH, 32'h41, 32'h0000BEEF, rd, er, lat);
`ifdef DMEM_MISALIGN_ERR_EN
      checks++; if (er !== 1'b1) begin errors++; $display("FAIL sh_misalign_err: got %b required 1", er); end
      do_req(1'b0, F3_LW, 32'h40, 32'h0, rd, er, lat);
      checks++; if (rd !== 32'h0) begin errors++; $display("FAIL sh_misalign_nowrite: got %h required 0", rd); end
      do_req(1'b0, F3_LW, 32'h11, 32'h0, rd, er, lat);
      checks++; if (er !== 1'b1 || rd !== 32'h0) begin errors++; $display("FAIL lw_misalign: got %h/%b required 0/1", rd, er); end
`else
      checks++; if (er !== 1'b0) begin errors++; $display("FAIL sh_misalign_err: got %b required 0", er); end
      do_req(1'b0, F3_LW, 32'h40, 32'h0, rd, er, lat);
      checks++; if (rd !== 32'h0000BEEF) begin errors++; $display("FAIL sh_misalign_aligned: got %h required 0000beef", rd); end
      do_req(1'b0, F3_LW, 32'h11, 32'h0, rd, er, lat);
      checks++; if (er !== 1'b0 || rd !== 32'hA5ADBEEF) begin errors++; $display("FAIL lw_misalign: got %h/%b required a5adbeef/0", rd, er); end
      do_req(1'b0, F3_LH, 32'h13, 32'h0, rd, er, lat);
      checks++; if (er !== 1'b0 || rd !== 32'hFFFFA5AD) begin errors++; $display("FAIL lh_misalign: got %h/%b required ffffa5ad/0", rd, er); end
`endif
   endtask

   task automatic test_reset_mid_op();
      logic [31:0] rd; logic er; int lat;
      do_req(1'b1, F3_SW, 32'h30, 32'hCAFEF00D, rd, er, lat);
      bus.req_we     = 1'b1;
      bus.req_funct3 = F3_SW;
      bus.req_addr   = 32'h30;
      bus.req_wdata  = 32'h12345678;
      bus.req_valid  = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.req_valid = 1'b0;
      checks++; if (dbg.state !== BUSY) begin errors++; $display("FAIL busy_before_rst: got %0d required BUSY", dbg.state); end
      @(posedge clk);
      #1 rst = 1'b1;
      #1;
      checks++;
      if (bus.req_ready !== 1'b1 || bus.rsp_valid !== 1'b0 || bus.rsp_err !== 1'b0 ||
          bus.rsp_rdata !== 32'h0 || dbg.state !== IDLE) begin
         errors++;
         $display("FAIL rst_busy_outputs: ready=%b valid=%b err=%b rdata=%h state=%0d required 1/0/0/0/IDLE",
                  bus.req_ready, bus.rsp_valid, bus.rsp_err, bus.rsp_rdata, dbg.state);
      end
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      do_req(1'b0, F3_LW, 32'h30, 32'h0, rd, er, lat);
      checks++; if (rd !== 32'hCAFEF00D || er !== 1'b0) begin errors++; $display("FAIL store_discarded: got %h/%b required cafef00d/0", rd, er); end
      bus.rsp_ready = 1'b0;
      do_req(1'b0, F3_LW, 32'h30, 32'h0, rd, er, lat);
      rst = 1'b1;
      #1;
      checks++;
      if (bus.rsp_valid !== 1'b0 || bus.rsp_rdata !== 32'h0 || bus.req_ready !== 1'b1) begin
         errors++;
         $display("FAIL rst_resp_drop: valid=%b rdata=%h ready=%b required 0/0/1", bus.rsp_valid, bus.rsp_rdata, bus.req_ready);
      end
      @(negedge clk);
      rst = 1'b0;
      bus.rsp_ready = 1'b1;
      @(negedge clk);
      do_req(1'b0, F3_LHU, 32'h32, 32'h0, rd, er, lat);
      checks++; if (rd !== 32'h0000CAFE || er !== 1'b0) begin errors++; $display("FAIL lhu_after_rst: got %h/%b required 0000cafe/0", rd, er); end
   endtask

   initial begin
      rst            = 1'b1;
      bus.req_valid  = 1'b0;
      bus.req_we     = 1'b0;
      bus.req_funct3 = 3'b000;
      bus.req_addr   = '0;
      bus.req_wdata  = '0;
      bus.rsp_ready  = 1'b1;
      test_reset();
      test_word();
      test_byte_half();
      test_backpressure();
      test_errors();
      test_reset_mid_op();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
